// File: rtl/uart_tx_8n1_if.sv
// Byte-in / serial-out handshake between the readout FSM (master) and the
// UART transmitter (slave).
interface uart_tx_8n1_if;
    logic       uart_tx_DV;
    logic [7:0] uart_tx_Byte;
    logic       uart_tx_Active;
    logic       uart_tx_Done;
    logic       uart_tx_Serial;

    modport master (
        output uart_tx_DV,
        output uart_tx_Byte,
        input  uart_tx_Active,
        input  uart_tx_Done,
        input  uart_tx_Serial
    );

    modport slave (
        input  uart_tx_DV,
        input  uart_tx_Byte,
        output uart_tx_Active,
        output uart_tx_Done,
        output uart_tx_Serial
    );
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter (1 or 2 stop bits) with a fixed clk-cycles-per-bit
// divider. All outputs are registered.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_8n1_if.slave bus
);
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_done;

    assign cnt_done = (cnt == CNT_LAST);

    // NOTE: every register here is assigned with <= so all state updates see
    // the pre-edge values of their neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            bit_idx            <= '0;
            shreg              <= '0;
            bus.uart_tx_Serial <= 1'b1;
            bus.uart_tx_Active <= 1'b0;
            bus.uart_tx_Done   <= 1'b0;
        end else begin
            bus.uart_tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.uart_tx_Serial <= 1'b1;
                    bus.uart_tx_Active <= 1'b0;
                    if (bus.uart_tx_DV) begin
                        shreg              <= bus.uart_tx_Byte;
                        cnt                <= '0;
                        bit_idx            <= '0;
                        state              <= START;
                        bus.uart_tx_Serial <= 1'b0;
                        bus.uart_tx_Active <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_done) begin
                        cnt                <= '0;
                        state              <= DATA;
                        bus.uart_tx_Serial <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    // shreg[0] always holds the bit currently on the line
                    if (cnt_done) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx            <= '0;
                            state              <= STOP;
                            bus.uart_tx_Serial <= 1'b1;
                        end else begin
                            bit_idx            <= bit_idx + 3'd1;
                            shreg              <= {1'b0, shreg[7:1]};
                            bus.uart_tx_Serial <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx            <= '0;
                            state              <= CLEANUP;
                            bus.uart_tx_Done   <= 1'b1;
                            bus.uart_tx_Active <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CLEANUP: begin
                    state              <= IDLE;
                    bus.uart_tx_Serial <= 1'b1;
                    bus.uart_tx_Active <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
